// File: rtl/md5_bf_pkg.sv
// Shared types, character constants, FSM states and the MD5 start-block builder
// used by the prefix dispatcher and its odometer.
`timescale 1ns/1ps
package md5_bf_pkg;

    typedef logic [511:0] md5_block_t;
    typedef logic [127:0] md5_hash_t;

    localparam logic [7:0] FIRST_CHAR = 8'h20;
    localparam logic [7:0] LAST_CHAR  = 8'h7E;
    localparam logic [7:0] PAD_BYTE   = 8'h80;

    // Widest prefix any build can carry: 55-char message minus two worker symbols.
    localparam int PREFIX_BYTES = 53;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } disp_state_t;

    // Prefix in bytes 0..L-3, spaces in L-2/L-1, 0x80 at L, bit length in bytes 56..63.
    function automatic md5_block_t build_block(input logic [5:0] len,
                                               input logic [PREFIX_BYTES*8-1:0] prefix);
        md5_block_t blk;
        int         n;
        n   = int'(len);
        blk = '0;
        for (int i = 0; i < 56; i++) begin
            blk[8*i +: 8] = (i == n) ? PAD_BYTE : ((i < n) ? FIRST_CHAR : 8'h00);
        end
        for (int i = 0; i < PREFIX_BYTES; i++) begin
            blk[8*i +: 8] = (i < n - 2) ? prefix[8*i +: 8] : blk[8*i +: 8];
        end
        blk[511:448] = {55'd0, len, 3'd0};
        return blk;
    endfunction

endpackage

// File: rtl/prefix_odometer.sv
// Printable-character odometer over the message prefix: byte 0 is the fastest
// digit, each digit runs 0x20..0x7E and carries into the next on wrap.
`timescale 1ns/1ps
module prefix_odometer
    import md5_bf_pkg::*;
#(
    parameter int DIGITS = 6
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  step,
    input  logic [5:0]            active_len,
    output logic [DIGITS*8-1:0]   digits_next,
    output logic                  last
);

    logic [DIGITS*8-1:0] count_r;
    logic                carry;

    // Next odometer value; digits beyond the active length never move.
    always_comb begin
        digits_next = count_r;
        carry       = 1'b1;
        if (clear) begin
            digits_next = {DIGITS{FIRST_CHAR}};
        end else if (step) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry && (i < int'(active_len))) begin
                    if (count_r[8*i +: 8] == LAST_CHAR) begin
                        digits_next[8*i +: 8] = FIRST_CHAR;
                    end else begin
                        digits_next[8*i +: 8] = count_r[8*i +: 8] + 8'd1;
                        carry                 = 1'b0;
                    end
                end else begin
                    carry = 1'b0;
                end
            end
        end else begin
            digits_next = count_r;
        end
    end

    // All active digits at their top value.
    always_comb begin
        last = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i < int'(active_len)) begin
                last = last & (count_r[8*i +: 8] == LAST_CHAR);
            end else begin
                last = last;
            end
        end
    end

    // Odometer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {DIGITS{FIRST_CHAR}};
        end else begin
            count_r <= digits_next;
        end
    end

endmodule

// File: rtl/md5_prefix_dispatcher.sv
// Job sequencer for the two-symbol MD5 brute-force worker: walks every printable
// prefix, restarting the worker per prefix. MD5_DISPATCH_PROGRESS_EN adds prefix_cnt.
`timescale 1ns/1ps
module md5_prefix_dispatcher
    import md5_bf_pkg::*;
#(
    parameter int MAX_LEN      = 8,
    parameter int DRAIN_CYCLES = 80
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_len,
    input  logic [127:0] cmd_hash,
    input  logic         abort,
    output logic         wk_ce,
    output logic         wk_reset,
    output logic         wk_reset_zero_string,
    output logic [511:0] wk_start_str,
    output logic [127:0] wk_hash,
    input  logic         wk_symbols_done,
    input  logic         wk_find_str,
    input  logic [511:0] wk_result_str,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [511:0] found_str
`ifdef MD5_DISPATCH_PROGRESS_EN
    ,
    output logic [31:0]  prefix_cnt
`endif
);

    localparam int DIGITS  = MAX_LEN - 2;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    disp_state_t                    state;
    logic [5:0]                     len_r;
    logic [DRAIN_W-1:0]             drain_cnt_r;
    logic                           accept;
    logic                           len_ok;
    logic                           odo_step;
    logic                           odo_last;
    logic [5:0]                     active_len;
    logic [DIGITS*8-1:0]            odo_next;
    logic [PREFIX_BYTES*8-1:0]      prefix_ext;

    // Command acceptance, length check and odometer control.
    always_comb begin
        if ((state == ST_IDLE) || (state == ST_DONE)) begin
            accept = cmd_valid;
        end else begin
            accept = 1'b0;
        end
        len_ok     = (cmd_len >= 6'd3) && (cmd_len <= 6'(MAX_LEN));
        active_len = len_r - 6'd2;
        if ((state == ST_NEXT) && !abort && !wk_find_str && !odo_last) begin
            odo_step = 1'b1;
        end else begin
            odo_step = 1'b0;
        end
    end

    // The block for an upcoming LOAD is built from the odometer's next value.
    always_comb begin
        prefix_ext = '0;
        for (int i = 0; i < DIGITS; i++) begin
            prefix_ext[8*i +: 8] = odo_next[8*i +: 8];
        end
    end

    prefix_odometer #(.DIGITS(DIGITS)) u_odometer (
        .clk         (clk),
        .reset       (reset),
        .clear       (accept),
        .step        (odo_step),
        .active_len  (active_len),
        .digits_next (odo_next),
        .last        (odo_last)
    );

    // Dispatcher FSM with registered outputs; abort outranks a match.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            len_r                <= 6'd0;
            drain_cnt_r          <= '0;
            cmd_ready            <= 1'b1;
            wk_ce                <= 1'b0;
            wk_reset             <= 1'b0;
            wk_reset_zero_string <= 1'b0;
            wk_start_str         <= '0;
            wk_hash              <= '0;
            busy                 <= 1'b0;
            found                <= 1'b0;
            exhausted            <= 1'b0;
            found_str            <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        len_r     <= cmd_len;
                        wk_hash   <= cmd_hash;
                        found     <= 1'b0;
                        found_str <= '0;
                        if (len_ok) begin
                            state                <= ST_LOAD;
                            exhausted            <= 1'b0;
                            wk_reset             <= 1'b1;
                            wk_reset_zero_string <= 1'b1;
                            wk_start_str         <= build_block(cmd_len, prefix_ext);
                            busy                 <= 1'b1;
                            cmd_ready            <= 1'b0;
                        end else begin
                            state     <= ST_DONE;
                            exhausted <= 1'b1;
                        end
                    end
                end
                ST_LOAD, ST_RUN, ST_NEXT, ST_DRAIN: begin
                    if (abort) begin
                        state                <= ST_IDLE;
                        wk_ce                <= 1'b0;
                        wk_reset             <= 1'b0;
                        wk_reset_zero_string <= 1'b0;
                        busy                 <= 1'b0;
                        cmd_ready            <= 1'b1;
                        found                <= 1'b0;
                        exhausted            <= 1'b0;
                    end else if (wk_find_str) begin
                        state                <= ST_DONE;
                        found                <= 1'b1;
                        found_str            <= wk_result_str;
                        wk_ce                <= 1'b0;
                        wk_reset             <= 1'b0;
                        wk_reset_zero_string <= 1'b0;
                        busy                 <= 1'b0;
                        cmd_ready            <= 1'b1;
                    end else begin
                        case (state)
                            ST_LOAD: begin
                                state                <= ST_RUN;
                                wk_reset             <= 1'b0;
                                wk_reset_zero_string <= 1'b0;
                                wk_ce                <= 1'b1;
                            end
                            ST_RUN: begin
                                if (wk_symbols_done) begin
                                    state <= ST_NEXT;
                                    wk_ce <= 1'b0;
                                end
                            end
                            ST_NEXT: begin
                                if (odo_last) begin
                                    state       <= ST_DRAIN;
                                    drain_cnt_r <= '0;
                                    wk_ce       <= 1'b1;
                                end else begin
                                    state                <= ST_LOAD;
                                    wk_reset             <= 1'b1;
                                    wk_reset_zero_string <= 1'b1;
                                    wk_start_str         <= build_block(len_r, prefix_ext);
                                end
                            end
                            ST_DRAIN: begin
                                if (drain_cnt_r == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                                    state     <= ST_DONE;
                                    exhausted <= 1'b1;
                                    wk_ce     <= 1'b0;
                                    busy      <= 1'b0;
                                    cmd_ready <= 1'b1;
                                end else begin
                                    drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    state                <= ST_IDLE;
                    wk_ce                <= 1'b0;
                    wk_reset             <= 1'b0;
                    wk_reset_zero_string <= 1'b0;
                    busy                 <= 1'b0;
                    cmd_ready            <= 1'b1;
                end
            endcase
        end
    end

`ifdef MD5_DISPATCH_PROGRESS_EN
    // Saturating count of NEXT states in the current job.
    always_ff @(posedge clk) begin
        if (reset) begin
            prefix_cnt <= 32'd0;
        end else if (accept) begin
            prefix_cnt <= 32'd0;
        end else if ((state == ST_NEXT) && (prefix_cnt != 32'hFFFF_FFFF)) begin
            prefix_cnt <= prefix_cnt + 32'd1;
        end else begin
            prefix_cnt <= prefix_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_md5_prefix_dispatcher.sv
// Directed self-checking bench for md5_prefix_dispatcher with a small behavioural
// worker model (one RUN cycle of latency, optional match on byte 0).
`timescale 1ns/1ps
module tb_md5_prefix_dispatcher;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [5:0]   cmd_len;
    logic [127:0] cmd_hash;
    logic         abort;
    logic         wk_ce;
    logic         wk_reset;
    logic         wk_reset_zero_string;
    logic [511:0] wk_start_str;
    logic [127:0] wk_hash;
    logic         wk_symbols_done;
    logic         wk_find_str;
    logic [511:0] wk_result_str;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [511:0] found_str;
`ifdef MD5_DISPATCH_PROGRESS_EN
    logic [31:0]  prefix_cnt;
`endif

    md5_prefix_dispatcher #(.MAX_LEN(8), .DRAIN_CYCLES(80)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_len              (cmd_len),
        .cmd_hash             (cmd_hash),
        .abort                (abort),
        .wk_ce                (wk_ce),
        .wk_reset             (wk_reset),
        .wk_reset_zero_string (wk_reset_zero_string),
        .wk_start_str         (wk_start_str),
        .wk_hash              (wk_hash),
        .wk_symbols_done      (wk_symbols_done),
        .wk_find_str          (wk_find_str),
        .wk_result_str        (wk_result_str),
        .busy                 (busy),
        .found                (found),
        .exhausted            (exhausted),
        .found_str            (found_str)
`ifdef MD5_DISPATCH_PROGRESS_EN
        ,
        .prefix_cnt           (prefix_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Worker model: symbols done on the second enabled cycle after its reset.
    logic [15:0] wk_cnt;
    logic        match_en;
    logic [7:0]  match_byte;

    always @(posedge clk) begin
        if (reset || wk_reset) wk_cnt <= 16'd0;
        else if (wk_ce)        wk_cnt <= wk_cnt + 16'd1;
    end

    assign wk_symbols_done = wk_ce && (wk_cnt == 16'd1);
    assign wk_find_str     = wk_symbols_done && match_en && (wk_start_str[7:0] == match_byte);

    always_comb begin
        wk_result_str        = wk_start_str;
        wk_result_str[15:8]  = 8'h62;
        wk_result_str[23:16] = 8'h63;
    end

    // Monitor: counts LOAD pulses, checks odometer order, timestamps the last NEXT.
    int          cyc = 0;
    int          load_cnt, order_err, ctl_cnt, next_cyc;
    logic [15:0] pfx94, pfx95, pfx_last;
    logic        clr_stats;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_stats) begin
            load_cnt  <= 0;
            order_err <= 0;
            ctl_cnt   <= 0;
            next_cyc  <= 0;
            pfx94     <= 16'h0000;
            pfx95     <= 16'h0000;
            pfx_last  <= 16'h0000;
        end else begin
            if (wk_reset || wk_ce) ctl_cnt <= ctl_cnt + 1;
            if (wk_ce && wk_symbols_done && !wk_find_str) next_cyc <= cyc + 1;
            if (wk_reset) begin
                load_cnt <= load_cnt + 1;
                pfx_last <= wk_start_str[15:0];
                if (load_cnt == 94) pfx94 <= wk_start_str[15:0];
                if (load_cnt == 95) pfx95 <= wk_start_str[15:0];
                if (wk_start_str[15:0] !== {8'h20 + 8'(load_cnt / 95), 8'h20 + 8'(load_cnt % 95)})
                    order_err <= order_err + 1;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] len, input logic [127:0] hash);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_hash  = hash;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
    endtask

    localparam logic [127:0] H_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] H_ALT = 128'h0123456789abcdeffedcba9876543210;

    logic [511:0] exp_blk;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = 6'd0; cmd_hash = '0;
        abort = 1'b0; match_en = 1'b0; match_byte = 8'h00; clr_stats = 1'b1;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wk_ce", wk_ce, 1'b0);
        chk("rst_wk_reset", wk_reset, 1'b0);
        chk("rst_start_str", wk_start_str, '0);
        chk("rst_found_str", found_str, '0);
        reset = 1'b0; clr_stats = 1'b0;
        step();

        abort = 1'b1; step(); abort = 1'b0;
        chk("idle_abort_ready", cmd_ready, 1'b1);
        chk("idle_abort_busy", busy, 1'b0);

        // L=3, match on 'a' -> "abc"
        match_en = 1'b1; match_byte = 8'h61;
        clear_stats();
        send(6'd3, H_ABC);
        exp_blk = '0;
        exp_blk[23:0]    = 24'h202020;
        exp_blk[31:24]   = 8'h80;
        exp_blk[455:448] = 8'h18;
        chk("load_wk_reset", wk_reset, 1'b1);
        chk("load_zero_str", wk_reset_zero_string, 1'b1);
        chk("load_wk_ce", wk_ce, 1'b0);
        chk("load_busy", busy, 1'b1);
        chk("load_cmd_ready", cmd_ready, 1'b0);
        chk("load_block", wk_start_str, exp_blk);
        chk("load_hash", wk_hash, H_ABC);
        step();
        chk("run_wk_ce", wk_ce, 1'b1);
        chk("run_wk_reset", wk_reset, 1'b0);
        for (int i = 0; i < 1000 && !wk_find_str; i++) step();
        chk("find_seen", wk_find_str, 1'b1);
        chk("found_before", found, 1'b0);
        step();
        chk("found_after", found, 1'b1);
        chk("found_bytes0_3", found_str[31:0], 32'h80636261);
        chk("found_byte56", found_str[455:448], 8'h18);
        chk("found_exhausted", exhausted, 1'b0);
        chk("found_wk_ce", wk_ce, 1'b0);
        chk("found_busy", busy, 1'b0);
        chk("found_cmd_ready", cmd_ready, 1'b1);
        step(); step(); step(); step();
        chk("match_load_cnt", load_cnt, 66);
        abort = 1'b1; step(); abort = 1'b0;
        chk("done_abort_found", found, 1'b1);

        // L=3 without a match: full space then drain
        match_en = 1'b0;
        clear_stats();
        send(6'd3, H_ALT);
        chk("accept_clr_found", found, 1'b0);
        chk("accept_clr_found_str", found_str, '0);
        for (int i = 0; i < 2000 && !exhausted; i++) step();
        chk("l3_exhausted", exhausted, 1'b1);
        chk("l3_drain_timing", cyc, next_cyc + 81);
        chk("l3_load_cnt", load_cnt, 95);
        chk("l3_order", order_err, 0);
        chk("l3_busy", busy, 1'b0);
        chk("l3_wk_ce", wk_ce, 1'b0);
        chk("l3_found", found, 1'b0);
`ifdef MD5_DISPATCH_PROGRESS_EN
        chk("l3_prefix_cnt", prefix_cnt, 32'd95);
`endif

        // L=4 odometer over 9025 prefixes
        clear_stats();
        send(6'd4, H_ALT);
        chk("l4_block_lo", wk_start_str[39:0], 40'h8020202020);
        chk("l4_byte56", wk_start_str[455:448], 8'h20);
        for (int i = 0; i < 40000 && !exhausted; i++) step();
        chk("l4_exhausted", exhausted, 1'b1);
        chk("l4_load_cnt", load_cnt, 9025);
        chk("l4_order", order_err, 0);
        chk("l4_pfx94", pfx94, 16'h207E);
        chk("l4_pfx95", pfx95, 16'h2120);
        chk("l4_pfx_last", pfx_last, 16'h7E7E);
`ifdef MD5_DISPATCH_PROGRESS_EN
        chk("l4_prefix_cnt", prefix_cnt, 32'd9025);
`endif

        // abort together with a match: abort wins
        match_en = 1'b1; match_byte = 8'h20;
        clear_stats();
        send(6'd3, H_ABC);
        for (int i = 0; i < 100 && !wk_find_str; i++) step();
        chk("ab_find_seen", wk_find_str, 1'b1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_wk_ce", wk_ce, 1'b0);
        chk("ab_cmd_ready", cmd_ready, 1'b1);
        chk("ab_found", found, 1'b0);
        chk("ab_exhausted", exhausted, 1'b0);
        chk("ab_wk_reset", wk_reset, 1'b0);

        // second command starts again from prefix 0x20, then reset mid-RUN
        match_en = 1'b0;
        send(6'd3, H_ALT);
        chk("second_load", wk_reset, 1'b1);
        chk("second_pfx", wk_start_str[7:0], 8'h20);
        chk("second_busy", busy, 1'b1);
        step();
        chk("second_run_ce", wk_ce, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_wk_ce", wk_ce, 1'b0);
        chk("mid_rst_zero_str", wk_reset_zero_string, 1'b0);
        chk("mid_rst_start_str", wk_start_str, '0);
        chk("mid_rst_hash", wk_hash, '0);

        // out-of-range lengths
        clear_stats();
        send(6'd2, H_ABC);
        chk("len2_exhausted", exhausted, 1'b1);
        chk("len2_busy", busy, 1'b0);
        chk("len2_ready", cmd_ready, 1'b1);
        send(6'd9, H_ABC);
        chk("len9_exhausted", exhausted, 1'b1);
        step(); step();
        chk("bad_len_no_ctl", ctl_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md5_prefix_dispatcher.md
# md5_prefix_dispatcher

Job sequencer feeding the two-symbol MD5 brute-force worker. It accepts a target hash and message length from the host, builds the MD5-padded 512-bit start block, and enumerates all printable prefixes of length L-2 with a counter. For each prefix it resets the worker, runs it until the worker reports both final symbols done, then advances. It stops on the first match or when the prefix space is exhausted.

## Interface
- MAX_LEN, 8: largest accepted message length in chars, at most 55.
- DRAIN_CYCLES, 80: cycles `wk_ce` stays high after the last prefix, covering worker pipeline latency.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high in IDLE and DONE.
- cmd_len  in  6  message length L in chars.
- cmd_hash  in  128  target digest {a,b,c,d}.
- abort  in  1  cancel the running job.
- wk_ce, wk_reset, wk_reset_zero_string  out  1  worker controls.
- wk_start_str  out  512  padded block to the worker.
- wk_hash  out  128  latched digest to the worker.
- wk_symbols_done, wk_find_str  in  1  worker status.
- wk_result_str  in  512  worker match block.
- busy, found, exhausted  out  1  job status.
- found_str  out  512  captured match.

## Operation
- Byte i of a block occupies bits [8i+7:8i].
- Block layout:
  - bytes 0..L-3 hold the prefix.
  - bytes L-2 and L-1 hold 0x20; the worker overwrites them.
  - byte L holds 0x80.
  - bytes 56..63 hold the bit length 8·L, little-endian.
  - all other bytes are 0.
- Odometer order:
  - byte 0 is the fastest digit, ranging 0x20..0x7E.
  - a digit wraps from 0x7E to 0x20 and carries into the next byte.
- States:
  - IDLE: waits for a command. On `cmd_valid` it latches L and the hash and sets all prefix bytes to 0x20. It goes to DONE with `exhausted=1` if L<3 or L>MAX_LEN, otherwise to LOAD.
  - LOAD, 1 cycle: `wk_reset=1` and `wk_reset_zero_string=1`; `wk_start_str` takes the new block. Next state is RUN.
  - RUN: `wk_ce=1`. When `wk_symbols_done` is sampled high, go to NEXT.
  - NEXT, 1 cycle, `wk_ce=0`: if every prefix byte is 0x7E, go to DRAIN; otherwise increment the odometer and go to LOAD.
  - DRAIN: `wk_ce=1` for DRAIN_CYCLES cycles, then DONE with `exhausted=1`.
  - DONE: status is held. `cmd_ready=1` and a new command is accepted exactly as from IDLE.
- Match: `wk_find_str=1` sampled in LOAD, RUN, NEXT or DRAIN has these effects:
  - `found_str` captures `wk_result_str`.
  - `found` goes to 1.
  - the state goes to DONE.
  - `wk_ce` drops to 0.
- `busy` is 1 in every state except IDLE and DONE.
- `wk_start_str` and `wk_hash` stay stable from LOAD through the end of RUN/DRAIN.
- Command acceptance clears `found`, `exhausted` and `found_str`.

## Timing
- Reset values: state IDLE; `cmd_ready=1`; all other outputs 0, including `found_str` and `wk_start_str`.
- Command accepted at edge n:
  - `wk_reset=1` during cycle n+1.
  - `wk_ce=1` from cycle n+2.
- `found` rises one cycle after `wk_find_str` is sampled.
- Simultaneous events:
  - `wk_find_str` and `wk_symbols_done` together: the match wins and no NEXT occurs.
  - `abort` and `wk_find_str` together: abort wins. State goes to IDLE, all worker controls drop to 0, `found` and `exhausted` are cleared, and `busy=0` the next cycle.
- `abort` in IDLE or DONE is ignored.
- `reset` mid-job: the state returns to IDLE the next cycle with all outputs at their reset values.
- Prefix count is 95^(L-2): L=3 gives 95, L=4 gives 9025.

## Configuration
- Macro `MD5_DISPATCH_PROGRESS_EN`.
- Defined: adds output `prefix_cnt` (32 bits).
  - cleared on command accept.
  - incremented once in each NEXT state.
  - saturates at 2^32-1.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `md5_bf_pkg` holds:
  - `md5_block_t` (logic [511:0]) and `md5_hash_t` (logic [127:0]).
  - `FIRST_CHAR=8'h20`, `LAST_CHAR=8'h7E`, `PAD_BYTE=8'h80`.
  - the state enum.
- Sub-module `prefix_odometer`: registered MAX_LEN-2 byte counter with `clear`, `step` and `last` (all digits 0x7E within the active length).

## Test plan
- L=3, hash 900150983cd24fb0d6963f7d28e17f72; worker model asserts find when byte0='a' → `found=1`; `found_str` bytes 0..3 are 61 62 63 80 and byte 56 is 0x18.
- L=3 with no match → 95 LOAD pulses, then `exhausted=1` DRAIN_CYCLES+1 cycles after the last NEXT; with PROGRESS_EN, `prefix_cnt=95`.
- L=4 odometer → prefix {0x7E,0x20} is followed by {0x20,0x21}; final prefix is {0x7E,0x7E}; 9025 prefixes in total.
- `abort` asserted mid-RUN → next cycle `busy=0`, `wk_ce=0`, `cmd_ready=1`; a second command is accepted and runs from prefix 0x20.
- `wk_find_str` and `wk_symbols_done` in the same cycle → DONE with `found=1`, no further LOAD; `reset` mid-RUN → all outputs return to reset values.
- `cmd_len=2` and `cmd_len=9` → DONE with `exhausted=1` on the next cycle; `wk_reset` and `wk_ce` are never asserted.
